// File: rtl/blur_window_ctrl.sv
// -----------------------------------------------------------------------------
// blur_window_ctrl
//   Streaming sequencer for a 3x3 blur kernel. It accepts a raster pixel
//   stream and keeps two line buffers plus a two-column window history. It
//   presents an edge-replicated 3x3 window to an external combinational
//   kernel. It registers the kernel result and emits one output pixel per
//   input pixel, in raster order.
//
// Ports
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   start       : one-cycle pulse that begins a frame (honoured only in IDLE)
//   in_valid    : input pixel handshake, producer side
//   in_ready    : input pixel handshake, this block's side
//   in_pix      : input pixel, raster order
//   win_bus     : kernel taps. p1 is in the top slice and p9 in the bottom
//                 slice. The bus is all-zero except in a cycle that issues a
//                 window.
//   k_o1        : kernel result, combinational from win_bus
//   out_valid   : output pixel handshake, this block's side
//   out_ready   : output pixel handshake, consumer side
//   out_pix     : blurred output pixel, raster order
//   busy        : a frame is in progress
//   done        : one-cycle pulse after the last output of a frame is taken
// -----------------------------------------------------------------------------
module blur_window_ctrl #(
   parameter int PIX_W = 4,
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PIX_W-1:0]   in_pix,
   output logic [9*PIX_W-1:0] win_bus,
   input  logic [PIX_W-1:0]   k_o1,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PIX_W-1:0]   out_pix,
   output logic               busy,
   output logic               done
);

   localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_RUN   = 3'd2,
      ST_EDGE  = 3'd3,
      ST_FLUSH = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // A window column is packed {top, middle, bottom}, with the top row in
   // the high bits.
   function automatic logic [9*PIX_W-1:0] pack_win(
      input logic [3*PIX_W-1:0] l,
      input logic [3*PIX_W-1:0] m,
      input logic [3*PIX_W-1:0] r
   );
      pack_win = {l[3*PIX_W-1 -: PIX_W], m[3*PIX_W-1 -: PIX_W], r[3*PIX_W-1 -: PIX_W],
                  l[2*PIX_W-1 -: PIX_W], m[2*PIX_W-1 -: PIX_W], r[2*PIX_W-1 -: PIX_W],
                  l[PIX_W-1:0],          m[PIX_W-1:0],          r[PIX_W-1:0]};
   endfunction

   state_t               state_r, state_s;
   logic [RW-1:0]        row_r;        // row of the next input pixel
   logic [CW-1:0]        col_r;        // column of the next input pixel
   logic [CW-1:0]        fcol_r;       // output column while flushing the last row
   logic                 last_row_r;   // final input row fully accepted
   logic [PIX_W-1:0]     line_a_r [IMG_W];   // most recent complete row
   logic [PIX_W-1:0]     line_b_r [IMG_W];   // row before line_a_r
   logic [3*PIX_W-1:0]   col_a_r;      // older captured column
   logic [3*PIX_W-1:0]   col_b_r;      // newer captured column
   logic [PIX_W-1:0]     out_pix_r;
   logic                 out_valid_r;
   logic                 done_r;

   logic                 stall_s;
   logic                 in_ready_s;
   logic                 accept_s;
   logic                 issue_s;
   logic [9*PIX_W-1:0]   win_s;
   logic [3*PIX_W-1:0]   ncol_s;
   logic [3*PIX_W-1:0]   run_left_s;
   logic [CW-1:0]        fidx_l_s;
   logic [CW-1:0]        fidx_r_s;
   logic [3*PIX_W-1:0]   fl_col_l_s;
   logic [3*PIX_W-1:0]   fl_col_m_s;
   logic [3*PIX_W-1:0]   fl_col_r_s;

   // A pending output that is not taken freezes the whole pipeline.
   assign stall_s    = out_valid_r & ~out_ready;
   assign in_ready_s = ((state_r == ST_FILL) || (state_r == ST_RUN)) & ~stall_s;
   assign accept_s   = in_valid & in_ready_s;

   // The column arriving with the current pixel: two rows above come from
   // the line buffers, and the bottom tap is the pixel itself.
   assign ncol_s     = {line_b_r[col_r], line_a_r[col_r], in_pix};
   // The first output of a row replicates column 0 as its left neighbour.
   assign run_left_s = (col_r == CW'(1)) ? col_b_r : col_a_r;

   // While flushing, the buffers are static. The bottom row clamps to the
   // last image row, which is held in line_a_r.
   assign fidx_l_s   = (fcol_r == CW'(0))   ? fcol_r : fcol_r - CW'(1);
   assign fidx_r_s   = (fcol_r == COL_LAST) ? fcol_r : fcol_r + CW'(1);
   assign fl_col_l_s = {line_b_r[fidx_l_s], line_a_r[fidx_l_s], line_a_r[fidx_l_s]};
   assign fl_col_m_s = {line_b_r[fcol_r],   line_a_r[fcol_r],   line_a_r[fcol_r]};
   assign fl_col_r_s = {line_b_r[fidx_r_s], line_a_r[fidx_r_s], line_a_r[fidx_r_s]};

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode and window issue
   always_comb begin
      state_s = state_r;
      issue_s = 1'b0;
      win_s   = {(9*PIX_W){1'b0}};
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_FILL;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FILL: begin
            // Pixel (1,0) is the only pixel accepted in FILL with row_r != 0.
            if (accept_s && (row_r != RW'(0))) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_FILL;
            end
         end
         ST_RUN: begin
            if (accept_s) begin
               if (col_r != CW'(0)) begin
                  issue_s = 1'b1;
                  win_s   = pack_win(run_left_s, col_b_r, ncol_s);
               end else begin
                  issue_s = 1'b0;
               end
               if (col_r == COL_LAST) begin
                  state_s = ST_EDGE;
               end else begin
                  state_s = ST_RUN;
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_EDGE: begin
            if (!stall_s) begin
               issue_s = 1'b1;
               win_s   = pack_win(col_a_r, col_b_r, col_b_r);
               if (last_row_r) begin
                  state_s = ST_FLUSH;
               end else begin
                  state_s = ST_RUN;
               end
            end else begin
               state_s = ST_EDGE;
            end
         end
         ST_FLUSH: begin
            if (!stall_s) begin
               issue_s = 1'b1;
               win_s   = pack_win(fl_col_l_s, fl_col_m_s, fl_col_r_s);
               if (fcol_r == COL_LAST) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_FLUSH;
               end
            end else begin
               state_s = ST_FLUSH;
            end
         end
         ST_DONE: begin
            // Hold until the final output has been taken.
            if (!stall_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Input position and flush column counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_r      <= RW'(0);
         col_r      <= CW'(0);
         fcol_r     <= CW'(0);
         last_row_r <= 1'b0;
      end else if ((state_r == ST_IDLE) && start) begin
         row_r      <= RW'(0);
         col_r      <= CW'(0);
         fcol_r     <= CW'(0);
         last_row_r <= 1'b0;
      end else if (accept_s) begin
         if (col_r == COL_LAST) begin
            col_r <= CW'(0);
            if (row_r == ROW_LAST) begin
               last_row_r <= 1'b1;
            end else begin
               row_r <= row_r + RW'(1);
            end
         end else begin
            col_r <= col_r + CW'(1);
         end
      end else if ((state_r == ST_FLUSH) && issue_s) begin
         fcol_r <= (fcol_r == COL_LAST) ? CW'(0) : fcol_r + CW'(1);
      end
   end

   // Line buffers. Row 0 fills both buffers, which replicates the top edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < IMG_W; i++) begin
            line_a_r[i] <= {PIX_W{1'b0}};
            line_b_r[i] <= {PIX_W{1'b0}};
         end
      end else if (accept_s) begin
         if (row_r == RW'(0)) begin
            line_a_r[col_r] <= in_pix;
            line_b_r[col_r] <= in_pix;
         end else begin
            line_a_r[col_r] <= in_pix;
            line_b_r[col_r] <= line_a_r[col_r];
         end
      end
   end

   // Two-column window history, advanced on every pixel from row 1 onward
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_a_r <= {(3*PIX_W){1'b0}};
         col_b_r <= {(3*PIX_W){1'b0}};
      end else if (accept_s && (row_r != RW'(0))) begin
         col_a_r <= col_b_r;
         col_b_r <= ncol_s;
      end
   end

   // Output register and the done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_pix_r   <= {PIX_W{1'b0}};
         out_valid_r <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         if (issue_s) begin
            out_pix_r   <= k_o1;
            out_valid_r <= 1'b1;
         end else if (out_ready) begin
            out_valid_r <= 1'b0;
         end
         done_r <= (state_r == ST_DONE) && !stall_s;
      end
   end

   assign in_ready  = in_ready_s;
   assign win_bus   = win_s;
   assign out_pix   = out_pix_r;
   assign out_valid = out_valid_r;
   assign busy      = (state_r != ST_IDLE);
   assign done      = done_r;

endmodule
